// File: rtl/chimera_cluster_pwr_seq_if.sv
// Power-sequencer control/status bundle between config registers and one cluster.
// pwr_cycles_o exists only when CHIMERA_PWR_SEQ_CYCLE_CNT_EN is defined.
interface chimera_cluster_pwr_seq_if;
    logic       pwr_req_i;
    logic       isolated_i;
    logic       clr_err_i;
    logic       clk_en_o;
    logic       cluster_rst_no;
    logic       isolate_req_o;
    logic       on_o;
    logic       timeout_o;
    logic [2:0] pwr_state_o;
`ifdef CHIMERA_PWR_SEQ_CYCLE_CNT_EN
    logic [15:0] pwr_cycles_o;
`endif

    modport master (
        output pwr_req_i, isolated_i, clr_err_i,
        input  clk_en_o, cluster_rst_no, isolate_req_o, on_o, timeout_o, pwr_state_o
`ifdef CHIMERA_PWR_SEQ_CYCLE_CNT_EN
        , input pwr_cycles_o
`endif
    );

    modport slave (
        input  pwr_req_i, isolated_i, clr_err_i,
        output clk_en_o, cluster_rst_no, isolate_req_o, on_o, timeout_o, pwr_state_o
`ifdef CHIMERA_PWR_SEQ_CYCLE_CNT_EN
        , output pwr_cycles_o
`endif
    );
endinterface

// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: orders clock gate, reset and AXI isolation on power-up/down.
// Optional power-up counter output enabled by CHIMERA_PWR_SEQ_CYCLE_CNT_EN.
module chimera_cluster_pwr_seq #(
    parameter int unsigned ResetHoldCycles = 8,
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned DrainTimeout    = 256
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    chimera_cluster_pwr_seq_if.slave  bus
);

    localparam int unsigned MaxA   = (ResetHoldCycles > ClkSettleCycles) ? ResetHoldCycles : ClkSettleCycles;
    localparam int unsigned MaxCyc = (MaxA > DrainTimeout) ? MaxA : DrainTimeout;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    localparam logic [CntW-1:0] HoldLd   = CntW'(ResetHoldCycles - 1);
    localparam logic [CntW-1:0] SettleLd = CntW'(ClkSettleCycles - 1);
    localparam logic [CntW-1:0] DrainLd  = CntW'(DrainTimeout - 1);

    typedef enum logic [2:0] {
        OFF        = 3'd0,
        CLK_ON     = 3'd1,
        RST_REL    = 3'd2,
        DEISO      = 3'd3,
        ON         = 3'd4,
        ISO        = 3'd5,
        RST_ASSERT = 3'd6,
        CLK_OFF    = 3'd7
    } pwrState_e;

    pwrState_e       state, stateNext;
    logic [CntW-1:0] cnt, cntNext;
    logic            timeoutQ, timeoutSet;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= OFF;
            cnt      <= '0;
            timeoutQ <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            // A new timeout takes priority over a simultaneous clear.
            if (timeoutSet)         timeoutQ <= 1'b1;
            else if (bus.clr_err_i) timeoutQ <= 1'b0;
        end
    end

    // The counter is reloaded with (length-1) on entry to every timed state.
    always_comb begin
        stateNext  = state;
        cntNext    = (cnt != '0) ? cnt - 1'b1 : cnt;
        timeoutSet = 1'b0;
        unique case (state)
            OFF: if (bus.pwr_req_i) begin
                stateNext = CLK_ON;
                cntNext   = HoldLd;
            end
            CLK_ON: if (cnt == '0) begin
                stateNext = RST_REL;
                cntNext   = SettleLd;
            end
            RST_REL: if (cnt == '0) stateNext = DEISO;
            DEISO:   if (!bus.isolated_i) stateNext = ON;
            ON: if (!bus.pwr_req_i) begin
                stateNext = ISO;
                cntNext   = DrainLd;
            end
            ISO: begin
                if (bus.isolated_i) begin
                    stateNext = RST_ASSERT;
                    cntNext   = HoldLd;
                end else if (cnt == '0) begin
                    stateNext  = DEISO;
                    timeoutSet = 1'b1;
                end
            end
            RST_ASSERT: if (cnt == '0) begin
                stateNext = CLK_OFF;
                cntNext   = SettleLd;
            end
            CLK_OFF: if (cnt == '0) stateNext = OFF;
            default: stateNext = OFF;
        endcase
    end

    always_comb begin
        bus.clk_en_o       = (state != OFF) && (state != CLK_OFF);
        bus.cluster_rst_no = (state == RST_REL) || (state == DEISO) ||
                             (state == ON) || (state == ISO);
        bus.isolate_req_o  = !((state == DEISO) || (state == ON));
        bus.on_o           = (state == ON);
        bus.timeout_o      = timeoutQ;
        bus.pwr_state_o    = state;
    end

`ifdef CHIMERA_PWR_SEQ_CYCLE_CNT_EN
    logic [15:0] pwrCycles;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            pwrCycles <= '0;
        else if ((state == OFF) && bus.pwr_req_i && (pwrCycles != 16'hFFFF))
            pwrCycles <= pwrCycles + 16'd1;
    end

    assign bus.pwr_cycles_o = pwrCycles;
`endif

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Directed bench for chimera_cluster_pwr_seq with default parameters (8/4/256).
module tb_chimera_cluster_pwr_seq;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   failures = 0;

    chimera_cluster_pwr_seq_if bus();

    chimera_cluster_pwr_seq dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_state"}, 16'(bus.pwr_state_o), 16'd0);
        check({tag, "_clken"}, 16'(bus.clk_en_o), 16'd0);
        check({tag, "_rstn"},  16'(bus.cluster_rst_no), 16'd0);
        check({tag, "_isoreq"}, 16'(bus.isolate_req_o), 16'd1);
        check({tag, "_on"},    16'(bus.on_o), 16'd0);
        check({tag, "_tmo"},   16'(bus.timeout_o), 16'd0);
    endtask

    // From OFF with isolated_i=1: request power, release isolation at cycle 15 -> ON at 16.
    task automatic powerUp();
        bus.pwr_req_i = 1'b1;
        tick(15);
        bus.isolated_i = 1'b0;
        tick(1);
    endtask

    initial begin
        bus.pwr_req_i  = 1'b0;
        bus.isolated_i = 1'b1;
        bus.clr_err_i  = 1'b0;
        #1;
        checkIdle("por");
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        checkIdle("idle");

        // Power-up timing; "cycle k" is k rising edges after pwr_req_i rises.
        bus.pwr_req_i = 1'b1;
        tick(1);
        check("up_c1_clken", 16'(bus.clk_en_o), 16'd1);
        check("up_c1_state", 16'(bus.pwr_state_o), 16'd1);
        tick(7);
        check("up_c8_rstn", 16'(bus.cluster_rst_no), 16'd0);
        tick(1);
        check("up_c9_rstn", 16'(bus.cluster_rst_no), 16'd1);
        check("up_c9_state", 16'(bus.pwr_state_o), 16'd2);
        tick(3);
        check("up_c12_isoreq", 16'(bus.isolate_req_o), 16'd1);
        tick(1);
        check("up_c13_isoreq", 16'(bus.isolate_req_o), 16'd0);
        check("up_c13_state", 16'(bus.pwr_state_o), 16'd3);
        tick(2);
        check("up_c15_on", 16'(bus.on_o), 16'd0);
        bus.isolated_i = 1'b0;
        tick(1);
        check("up_c16_on", 16'(bus.on_o), 16'd1);
        check("up_c16_state", 16'(bus.pwr_state_o), 16'd4);

        // Power-down with drain completing after 20 cycles.
        bus.pwr_req_i = 1'b0;
        tick(1);
        check("dn_c1_state", 16'(bus.pwr_state_o), 16'd5);
        check("dn_c1_rstn", 16'(bus.cluster_rst_no), 16'd1);
        check("dn_c1_isoreq", 16'(bus.isolate_req_o), 16'd1);
        check("dn_c1_on", 16'(bus.on_o), 16'd0);
        tick(19);
        check("dn_c20_state", 16'(bus.pwr_state_o), 16'd5);
        bus.isolated_i = 1'b1;
        tick(1);
        check("dn_c21_state", 16'(bus.pwr_state_o), 16'd6);
        check("dn_c21_rstn", 16'(bus.cluster_rst_no), 16'd0);
        check("dn_c21_clken", 16'(bus.clk_en_o), 16'd1);
        tick(7);
        check("dn_c28_clken", 16'(bus.clk_en_o), 16'd1);
        tick(1);
        check("dn_c29_clken", 16'(bus.clk_en_o), 16'd0);
        check("dn_c29_state", 16'(bus.pwr_state_o), 16'd7);
        tick(3);
        check("dn_c32_state", 16'(bus.pwr_state_o), 16'd7);
        tick(1);
        checkIdle("dn_c33");

        // Drain timeout: ISO occupies cycles 1..256, abort lands in DEISO at 257.
        powerUp();
        check("tmo_on", 16'(bus.on_o), 16'd1);
        bus.pwr_req_i = 1'b0;
        tick(256);
        check("tmo_c256_state", 16'(bus.pwr_state_o), 16'd5);
        check("tmo_c256_tmo", 16'(bus.timeout_o), 16'd0);
        tick(1);
        check("tmo_c257_state", 16'(bus.pwr_state_o), 16'd3);
        check("tmo_c257_tmo", 16'(bus.timeout_o), 16'd1);
        check("tmo_c257_isoreq", 16'(bus.isolate_req_o), 16'd0);
        tick(1);
        check("tmo_c258_on", 16'(bus.on_o), 16'd1);
        tick(1);
        check("tmo_c259_retry", 16'(bus.pwr_state_o), 16'd5);
        bus.clr_err_i = 1'b1;
        tick(1);
        bus.clr_err_i = 1'b0;
        check("tmo_clr", 16'(bus.timeout_o), 16'd0);
        // Retry entered ISO at 259, so its timeout edge is 515; clear on that same edge.
        tick(254);
        check("tmo_c514_state", 16'(bus.pwr_state_o), 16'd5);
        bus.clr_err_i = 1'b1;
        tick(1);
        bus.clr_err_i = 1'b0;
        check("tmo_setwins", 16'(bus.timeout_o), 16'd1);
        check("tmo_c515_state", 16'(bus.pwr_state_o), 16'd3);
        tick(1);
        bus.clr_err_i = 1'b1;
        tick(1);
        bus.clr_err_i = 1'b0;
        check("tmo_c517_state", 16'(bus.pwr_state_o), 16'd5);
        check("tmo_c517_tmo", 16'(bus.timeout_o), 16'd0);
        // Drain arrives on the last ISO cycle: isolation wins, no error.
        tick(255);
        bus.isolated_i = 1'b1;
        tick(1);
        check("race_state", 16'(bus.pwr_state_o), 16'd6);
        check("race_tmo", 16'(bus.timeout_o), 16'd0);
        tick(12);
        checkIdle("race_off");

        // Short request pulse: sequence still runs to ON, then leaves immediately.
        bus.pwr_req_i = 1'b1;
        tick(3);
        bus.pwr_req_i = 1'b0;
        tick(10);
        check("tog_c13_state", 16'(bus.pwr_state_o), 16'd3);
        bus.isolated_i = 1'b0;
        tick(1);
        check("tog_c14_on", 16'(bus.on_o), 16'd1);
        tick(1);
        check("tog_c15_state", 16'(bus.pwr_state_o), 16'd5);

        // Asynchronous reset in the middle of ISO.
        tick(5);
        #2;
        rst_ni = 1'b0;
        #1;
        checkIdle("rst_iso");
        bus.isolated_i = 1'b1;
        tick(2);
        rst_ni = 1'b1;
        tick(1);

`ifdef CHIMERA_PWR_SEQ_CYCLE_CNT_EN
        check("cnt_rst", bus.pwr_cycles_o, 16'd0);
        for (int k = 0; k < 3; k++) begin
            powerUp();
            bus.pwr_req_i = 1'b0;
            tick(1);
            bus.isolated_i = 1'b1;
            tick(13);
        end
        check("cnt_three", bus.pwr_cycles_o, 16'd3);
        force dut.pwrCycles = 16'hFFFF;
        tick(1);
        release dut.pwrCycles;
        powerUp();
        check("cnt_sat", bus.pwr_cycles_o, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chimera_cluster_pwr_seq.md
Name: chimera_cluster_pwr_seq

Overview:
Per-cluster power sequencer. One instance per external cluster, ExtClusters instances in total. It sits between the top-level config registers, which drive the power request, and the cluster's clock gate, reset and AXI isolation cell. It orders clock enable, reset and AXI isolation on power-up and power-down so clusters can be gated safely in the isolate-enabled configuration. If the AXI drain does not complete in time, it aborts the power-down and flags a sticky error.

Parameters:
ResetHoldCycles, 8, cycles reset is held after clock on, and before clock off; must be >=1.
ClkSettleCycles, 4, cycles waited after reset release, and after clock disable; must be >=1.
DrainTimeout, 256, maximum cycles to wait for isolated_i during power-down; must be >=1.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
pwr_req_i  in  1  1 = cluster should be on, 0 = off (level, from config regs)
isolated_i  in  1  isolation cell status; 1 = all outstanding AXI transactions drained and ports blocked
clr_err_i  in  1  single-cycle pulse; clears timeout_o
clk_en_o  out  1  cluster clock-gate enable
cluster_rst_no  out  1  cluster reset, active-low
isolate_req_o  out  1  request AXI isolation
on_o  out  1  1 only in state ON
timeout_o  out  1  sticky drain-timeout error
pwr_state_o  out  3  current FSM state encoding

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- State encoding: OFF=0, CLK_ON=1, RST_REL=2, DEISO=3, ON=4, ISO=5, RST_ASSERT=6, CLK_OFF=7.
- Reset values: state OFF, clk_en_o=0, cluster_rst_no=0, isolate_req_o=1, on_o=0, timeout_o=0, pwr_state_o=0.
- Output decode:
  - clk_en_o=1 in CLK_ON, RST_REL, DEISO, ON, ISO, RST_ASSERT.
  - cluster_rst_no=1 in RST_REL, DEISO, ON, ISO.
  - isolate_req_o=0 in DEISO and ON; 1 otherwise.
- A single down-counter serves all timed states. It loads on state entry; width is $clog2 of the largest parameter, +1.
- OFF: if pwr_req_i=1, go to CLK_ON next cycle.
- CLK_ON: stay exactly ResetHoldCycles cycles, then go to RST_REL.
- RST_REL: stay exactly ClkSettleCycles cycles, then go to DEISO.
- DEISO: wait with no timeout; when isolated_i=0 is sampled, go to ON next cycle.
- ON: if pwr_req_i=0, go to ISO next cycle.
- ISO:
  - If isolated_i=1 is sampled, go to RST_ASSERT.
  - Else, after DrainTimeout cycles in ISO, set timeout_o and go to DEISO; this is the abort path, and the FSM returns to ON.
  - If isolated_i=1 arrives on the timeout cycle, isolated_i wins and no error is set.
- RST_ASSERT: stay ResetHoldCycles cycles, then go to CLK_OFF.
- CLK_OFF: stay ClkSettleCycles cycles, then go to OFF.
- pwr_req_i is evaluated only in OFF and ON. A sequence in progress always completes; a toggle mid-sequence takes effect on return to OFF or ON.
- After an abort, pwr_req_i=0 re-enters ISO at once, so a stuck drain retries.
- timeout_o: sticky. clr_err_i clears it; if set and clear occur in the same cycle, set wins.
- Reset mid-sequence: asynchronously returns to OFF with reset values. Clock is gated and the cluster is held in reset and isolated.

Optional Feature:
CHIMERA_PWR_SEQ_CYCLE_CNT_EN:
- Defined: adds output port pwr_cycles_o [15:0]. It increments by 1 on every OFF->CLK_ON transition and saturates at 16'hFFFF. Reset value 0; clr_err_i does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst_ni=0 mid-ISO -> immediately pwr_state_o=0, clk_en_o=0, cluster_rst_no=0, isolate_req_o=1, timeout_o=0.
- Power-up timing (defaults): pwr_req_i=1 at cycle 0, isolated_i drops at cycle 15 ->
  - clk_en_o=1 at cycle 1;
  - cluster_rst_no=1 at cycle 9;
  - isolate_req_o=0 at cycle 13;
  - on_o=1 at cycle 16.
- Power-down: from ON, pwr_req_i=0, isolated_i=1 after 20 cycles ->
  - cluster_rst_no=0 for 8 cycles;
  - then clk_en_o=0;
  - pwr_state_o=0 4 cycles later;
  - timeout_o stays 0.
- Drain timeout: isolated_i held 0 in ISO ->
  - after 256 cycles timeout_o=1, isolate_req_o=0, FSM returns to ON;
  - clr_err_i pulse clears timeout_o;
  - with simultaneous set and clear, timeout_o=1.
- Mid-sequence toggle: pwr_req_i pulses 1 for 3 cycles from OFF -> full power-up completes to ON, then immediately ISO.
- With CHIMERA_PWR_SEQ_CYCLE_CNT_EN: 3 full on/off cycles -> pwr_cycles_o=3. Forced to 16'hFFFF, one more cycle -> still 16'hFFFF.
